vga_scanout: RTL and testbench

Parametrised successor VGA scan-out engine with integrated h/v timing counters. It adds a framebuffer base address, a line stride, 2x pixel/line doubling, a line-compare interrupt and shadowed (frame-synchronous) configuration registers. It drives sync and RGB pins and a pixel fetch address to a framebuffer memory with 1-cycle read latency. The register port runs on i_vgaclk, so there is no CDC inside the block.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_scanout_if.sv | 13 +
 rtl/vga_scan_counter.sv | 48 ++++
 rtl/vga_scanout.sv | 187 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared register map, CTRL and IRQ bit positions for the VGA scan-out block.
// No logic; constants only.
// Imported by the scan counter, the register interface users and the top.
package vga_pkg;

    localparam logic [3:0] REG_HSYNC_START = 4'd0;
    localparam logic [3:0] REG_HBP_START   = 4'd1;
    localparam logic [3:0] REG_HVIS_START  = 4'd2;
    localparam logic [3:0] REG_HEND        = 4'd3;
    localparam logic [3:0] REG_VSYNC_START = 4'd4;
    localparam logic [3:0] REG_VBP_START   = 4'd5;
    localparam logic [3:0] REG_VVIS_START  = 4'd6;
    localparam logic [3:0] REG_VEND        = 4'd7;
    localparam logic [3:0] REG_CTRL        = 4'd8;
    localparam logic [3:0] REG_FB_LO       = 4'd9;
    localparam logic [3:0] REG_FB_HI       = 4'd10;
    localparam logic [3:0] REG_STRIDE      = 4'd11;
    localparam logic [3:0] REG_LINE_CMP    = 4'd12;
    localparam logic [3:0] REG_IRQ_STATUS  = 4'd13;
    localparam logic [3:0] REG_IRQ_EN      = 4'd14;

    // Registers 0..12 are shadowed (pending copy + frame-synchronous active copy).
    localparam int NUM_SHADOW = 13;

    localparam int CTRL_HPOL = 0;
    localparam int CTRL_VPOL = 1;
    localparam int CTRL_EN   = 2;
    localparam int CTRL_HDBL = 4;
    localparam int CTRL_VDBL = 5;

    localparam int IRQ_FRAME = 0;
    localparam int IRQ_LINE  = 1;

endpackage

// File: rtl/vga_scanout_if.sv
// Register access port of the scan-out block (same clock as the pixel clock).
// Writes take effect on the next edge; read data is combinational.
// No backpressure: one access per cycle is always accepted.
interface vga_scanout_if;
    logic [3:0]  reg_addr;
    logic [15:0] reg_wdat;
    logic [1:0]  reg_sel;
    logic        reg_we;
    logic [15:0] reg_rdat;

    modport master (output reg_addr, reg_wdat, reg_sel, reg_we, input reg_rdat);
    modport slave  (input reg_addr, reg_wdat, reg_sel, reg_we, output reg_rdat);
endinterface

// File: rtl/vga_scan_counter.sv
// Horizontal/vertical position counters with region decode and end-of-frame strobe.
// Counters registered; region flags are combinational from the current position.
// No backpressure; held at (0,0) while disabled.
module vga_scan_counter #(
    parameter int CW = 11
) (
    input  logic          i_vgaclk,
    input  logic          i_reset,
    input  logic          enable,
    input  logic [CW-1:0] hsync_start,
    input  logic [CW-1:0] hbp_start,
    input  logic [CW-1:0] hvis_start,
    input  logic [CW-1:0] hend,
    input  logic [CW-1:0] vsync_start,
    input  logic [CW-1:0] vbp_start,
    input  logic [CW-1:0] vvis_start,
    input  logic [CW-1:0] vend,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          h_sync,
    output logic          v_sync,
    output logic          v_vis,
    output logic          pix_vis,
    output logic          line_end,
    output logic          frame_end
);

    // Advance the raster position; >= keeps the counters bounded whatever the limits hold.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset || !enable) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt >= hend) begin
            hcnt <= '0;
            vcnt <= (vcnt >= vend) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign h_sync    = (hcnt >= hsync_start) && (hcnt < hbp_start);
    assign v_sync    = (vcnt >= vsync_start) && (vcnt < vbp_start);
    assign v_vis     = (vcnt >= vvis_start);
    assign pix_vis   = (hcnt >= hvis_start) && v_vis;
    assign line_end  = (hcnt == hend);
    assign frame_end = line_end && (vcnt == vend);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: shadowed config registers, framebuffer address generation, sync/RGB pins, IRQ.
// Pins lag the raster position by 2 cycles; fetch address by 1; memory read latency is 1.
// No backpressure: the framebuffer must return data every cycle.
module vga_scanout import vga_pkg::*; #(
    parameter  int CW     = 11,
    parameter  int AW     = 24,
    parameter  int R_BITS = 3,
    parameter  int G_BITS = 3,
    parameter  int B_BITS = 2,
    localparam int PW     = R_BITS + G_BITS + B_BITS
) (
    input  logic              i_vgaclk,
    input  logic              i_reset,
    vga_scanout_if.slave      regs,
    output logic [AW-1:0]     o_pixAddr,
    input  logic [PW-1:0]     i_pixData,
    output logic              o_hSync,
    output logic              o_vSync,
    output logic [R_BITS-1:0] o_red,
    output logic [G_BITS-1:0] o_green,
    output logic [B_BITS-1:0] o_blue,
    output logic              o_irq
);

    logic [15:0] pend [NUM_SHADOW];
    logic [15:0] act  [NUM_SHADOW];
    logic [1:0]  irq_status, irq_en, irq_set, irq_clr;
    logic [15:0] wmask;
    logic [31:0] fb_pend;
    logic [AW-1:0] stride_ext, line_addr, xoff;
    logic        hph, vodd, en, shadow_load, unused_act;
    logic [CW-1:0] hcnt, vcnt;
    logic        h_sync, v_sync, v_vis, pix_vis, line_end, frame_end;
    logic        s1_vis, s1_hlev, s1_vlev;

    // Implemented bits per register; everything else is stored and read as 0.
    function automatic logic [15:0] reg_mask(input int idx);
        logic [31:0] m;
        case (idx)
            int'(REG_CTRL):                    m = 32'h0000_0037;
            int'(REG_FB_HI):                   m = (32'd1 << (AW - 16)) - 32'd1;
            int'(REG_FB_LO), int'(REG_STRIDE): m = 32'h0000_FFFF;
            default:                           m = (32'd1 << CW) - 32'd1;
        endcase
        return m[15:0];
    endfunction

    assign wmask       = {{8{regs.reg_sel[1]}}, {8{regs.reg_sel[0]}}};
    assign en          = act[REG_CTRL][CTRL_EN];
    assign shadow_load = frame_end || !en;
    assign fb_pend     = {pend[REG_FB_HI], pend[REG_FB_LO]};
    assign stride_ext  = {{(AW-16){1'b0}}, act[REG_STRIDE]};

    // Pending register writes with byte enables.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_SHADOW; i++) pend[i] <= '0;
        end else if (regs.reg_we) begin
            for (int i = 0; i < NUM_SHADOW; i++)
                if (regs.reg_addr == i[3:0])
                    pend[i] <= ((pend[i] & ~wmask) | (regs.reg_wdat & wmask)) & reg_mask(i);
        end
    end

    // Active copy follows pending at frame start, or continuously while disabled.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_SHADOW; i++) act[i] <= '0;
        end else if (shadow_load) begin
            for (int i = 0; i < NUM_SHADOW; i++) act[i] <= pend[i];
        end
    end

    // Not every active bit is consumed (narrow fields); fold them so intent is explicit.
    always_comb begin
        unused_act = 1'b0;
        for (int i = 0; i < NUM_SHADOW; i++) unused_act = unused_act ^ (^act[i]);
    end

    // Combinational register readback of the pending values and live IRQ registers.
    always_comb begin
        regs.reg_rdat = '0;
        for (int i = 0; i < NUM_SHADOW; i++)
            if (regs.reg_addr == i[3:0]) regs.reg_rdat = pend[i];
        if (regs.reg_addr == REG_IRQ_STATUS) regs.reg_rdat = {14'd0, irq_status};
        if (regs.reg_addr == REG_IRQ_EN)     regs.reg_rdat = {14'd0, irq_en};
    end

    vga_scan_counter #(.CW(CW)) u_cnt (
        .i_vgaclk    (i_vgaclk),
        .i_reset     (i_reset),
        .enable      (en),
        .hsync_start (act[REG_HSYNC_START][CW-1:0]),
        .hbp_start   (act[REG_HBP_START][CW-1:0]),
        .hvis_start  (act[REG_HVIS_START][CW-1:0]),
        .hend        (act[REG_HEND][CW-1:0]),
        .vsync_start (act[REG_VSYNC_START][CW-1:0]),
        .vbp_start   (act[REG_VBP_START][CW-1:0]),
        .vvis_start  (act[REG_VVIS_START][CW-1:0]),
        .vend        (act[REG_VEND][CW-1:0]),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .v_vis       (v_vis),
        .pix_vis     (pix_vis),
        .line_end    (line_end),
        .frame_end   (frame_end)
    );

    // Line base and in-line offset; the frame base comes from pending so it matches the new active copy.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            line_addr <= '0;
            vodd      <= 1'b0;
            xoff      <= '0;
            hph       <= 1'b0;
        end else begin
            if (shadow_load) begin
                line_addr <= fb_pend[AW-1:0];
                vodd      <= 1'b0;
            end else if (line_end && v_vis) begin
                if (!act[REG_CTRL][CTRL_VDBL] || vodd) line_addr <= line_addr + stride_ext;
                vodd <= ~vodd;
            end
            if (!en || line_end) begin
                xoff <= '0;
                hph  <= 1'b0;
            end else if (pix_vis) begin
                if (!act[REG_CTRL][CTRL_HDBL] || hph) xoff <= xoff + 1'b1;
                hph <= act[REG_CTRL][CTRL_HDBL] & ~hph;
            end
        end
    end

    // Stage 1: fetch address plus sync/blank levels that travel alongside it.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            o_pixAddr <= '0;
            s1_vis    <= 1'b0;
            s1_hlev   <= 1'b1;
            s1_vlev   <= 1'b1;
        end else begin
            if (en && pix_vis) o_pixAddr <= line_addr + xoff;
            s1_vis  <= en && pix_vis;
            s1_hlev <= ~((en && h_sync) ^ act[REG_CTRL][CTRL_HPOL]);
            s1_vlev <= ~((en && v_sync) ^ act[REG_CTRL][CTRL_VPOL]);
        end
    end

    // Stage 2: pins, with fetched colour gated by the delayed blank.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            o_hSync <= 1'b1;
            o_vSync <= 1'b1;
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
        end else begin
            o_hSync <= s1_hlev;
            o_vSync <= s1_vlev;
            o_red   <= s1_vis ? i_pixData[R_BITS-1:0]               : '0;
            o_green <= s1_vis ? i_pixData[R_BITS +: G_BITS]          : '0;
            o_blue  <= s1_vis ? i_pixData[R_BITS+G_BITS +: B_BITS]   : '0;
        end
    end

    assign irq_set[IRQ_FRAME] = en && (hcnt == '0) && (vcnt == '0);
    assign irq_set[IRQ_LINE]  = en && (hcnt == '0) && (vcnt == act[REG_LINE_CMP][CW-1:0]);
    assign irq_clr = (regs.reg_we && regs.reg_addr == REG_IRQ_STATUS && regs.reg_sel[0])
                     ? regs.reg_wdat[1:0] : 2'b00;

    // IRQ status is write-1-to-clear with set taking priority; enable is a plain register.
    always_ff @(posedge i_vgaclk) begin
        if (i_reset) begin
            irq_status <= '0;
            irq_en     <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | irq_set;
            if (regs.reg_we && regs.reg_addr == REG_IRQ_EN && regs.reg_sel[0])
                irq_en <= regs.reg_wdat[1:0];
        end
    end

    assign o_irq = |(irq_status & irq_en);

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: expected pins/addresses are queued per raster position.
// Alignment is taken from the frame interrupt, then every cycle is predicted and compared.
// Framebuffer is modelled as data = f(address) returned in the cycle after the address.
module tb_vga_scanout;

    logic        clk;
    logic        i_reset;
    logic [23:0] pix_addr;
    logic [7:0]  pix_data;
    logic        hsync, vsync, irq;
    logic [2:0]  red, green;
    logic [1:0]  blue;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        vis;
        logic [23:0] addr;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t addr_q[$];
    exp_t pin_q[$];

    // raster model
    int m_h, m_v;
    int m_hs, m_hbp, m_hvis, m_hend, m_hend_pend;
    int m_vs, m_vbp, m_vvis, m_vend;
    int m_base, m_stride, m_lcmp;
    logic m_hdbl, m_vdbl, m_hpol, m_vpol;
    logic [1:0] m_status, m_en;

    vga_scanout_if rif();

    function automatic logic [7:0] pixf(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    assign pix_data = pixf(pix_addr);

    vga_scanout dut (
        .i_vgaclk  (clk),
        .i_reset   (i_reset),
        .regs      (rif),
        .o_pixAddr (pix_addr),
        .i_pixData (pix_data),
        .o_hSync   (hsync),
        .o_vSync   (vsync),
        .o_red     (red),
        .o_green   (green),
        .o_blue    (blue),
        .o_irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        rif.reg_we = 1'b1; rif.reg_addr = a; rif.reg_wdat = d; rif.reg_sel = 2'b11;
        @(negedge clk);
        rif.reg_we = 1'b0;
    endtask

    // One raster cycle: predict, compare the due entries, update the IRQ model, advance.
    task automatic scan_step();
        exp_t e, p;
        int x, y, xo, ln, a;
        logic [1:0] clr, set;
        logic [7:0] col;
        checks++;
        if (irq !== |(m_status & m_en)) begin
            errors++;
            $display("FAIL irq at (%0d,%0d): got %b want %b", m_h, m_v, irq, |(m_status & m_en));
        end
        x = m_h - m_hvis; y = m_v - m_vvis;
        xo = m_hdbl ? x / 2 : x;
        ln = m_vdbl ? y / 2 : y;
        a = m_base + ln * m_stride + xo;
        e.vis  = (m_h >= m_hvis) && (m_v >= m_vvis);
        e.addr = a[23:0];
        e.hs   = (m_h >= m_hs && m_h < m_hbp) ? m_hpol : !m_hpol;
        e.vs   = (m_v >= m_vs && m_v < m_vbp) ? m_vpol : !m_vpol;
        addr_q.push_back(e);
        pin_q.push_back(e);
        if (addr_q.size() == 2) begin
            p = addr_q.pop_front();
            if (p.vis) begin
                checks++;
                if (pix_addr !== p.addr) begin
                    errors++;
                    $display("FAIL pixaddr: got %h want %h", pix_addr, p.addr);
                end
            end
        end
        if (pin_q.size() == 3) begin
            p = pin_q.pop_front();
            col = p.vis ? pixf(p.addr) : 8'h00;
            checks++;
            if (hsync !== p.hs) begin errors++; $display("FAIL hsync: got %b want %b", hsync, p.hs); end
            checks++;
            if (vsync !== p.vs) begin errors++; $display("FAIL vsync: got %b want %b", vsync, p.vs); end
            checks++;
            if ({blue, green, red} !== col) begin
                errors++;
                $display("FAIL colour: got %h want %h", {blue, green, red}, col);
            end
        end
        clr = (rif.reg_we && rif.reg_addr == 4'd13 && rif.reg_sel[0]) ? rif.reg_wdat[1:0] : 2'b00;
        set[0] = (m_h == 0) && (m_v == 0);
        set[1] = (m_h == 0) && (m_v == m_lcmp);
        m_status = (m_status & ~clr) | set;
        if (rif.reg_we && rif.reg_addr == 4'd14 && rif.reg_sel[0]) m_en = rif.reg_wdat[1:0];
        if (m_h == m_hend) begin
            m_h = 0;
            if (m_v == m_vend) begin m_v = 0; m_hend = m_hend_pend; end
            else m_v++;
        end else begin
            m_h++;
        end
        @(negedge clk);
    endtask

    // Reset, program 10x6 timing, enable with frame IRQ, align on the first frame interrupt.
    task automatic configure(input logic hdbl, vdbl, hpol, vpol, input int lcmp);
        int n;
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        write_reg(4'd0, 16'd2); write_reg(4'd1, 16'd4); write_reg(4'd2, 16'd6); write_reg(4'd3, 16'd9);
        write_reg(4'd4, 16'd1); write_reg(4'd5, 16'd2); write_reg(4'd6, 16'd3); write_reg(4'd7, 16'd5);
        write_reg(4'd9, 16'h0100); write_reg(4'd10, 16'h0000); write_reg(4'd11, 16'd8);
        write_reg(4'd12, 16'(lcmp)); write_reg(4'd14, 16'd1);
        write_reg(4'd8, {10'd0, vdbl, hdbl, 1'b0, 1'b1, vpol, hpol});
        m_hs = 2; m_hbp = 4; m_hvis = 6; m_hend = 9; m_hend_pend = 9;
        m_vs = 1; m_vbp = 2; m_vvis = 3; m_vend = 5;
        m_base = 'h100; m_stride = 8; m_lcmp = lcmp;
        m_hdbl = hdbl; m_vdbl = vdbl; m_hpol = hpol; m_vpol = vpol;
        n = 0;
        while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL frame_irq_anchor: got %b want 1", irq); end
        m_h = 1; m_v = 0; m_status = 2'b01; m_en = 2'b01;
        addr_q.delete(); pin_q.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (hsync !== 1'b1)     begin errors++; $display("FAIL rst_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1)     begin errors++; $display("FAIL rst_vsync: got %b want 1", vsync); end
        checks++; if ({blue, green, red} !== 8'h00) begin errors++; $display("FAIL rst_colour: got %h want 00", {blue, green, red}); end
        checks++; if (pix_addr !== 24'h0) begin errors++; $display("FAIL rst_pixaddr: got %h want 0", pix_addr); end
        checks++; if (irq !== 1'b0)       begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
        for (int i = 0; i < 16; i++) begin
            rif.reg_addr = 4'(i);
            #1;
            checks++;
            if (rif.reg_rdat !== 16'h0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0", i, rif.reg_rdat); end
        end
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_scan();
        configure(1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (125) scan_step();
    endtask

    task automatic test_double();
        configure(1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (70) scan_step();
    endtask

    task automatic test_hend_change();
        configure(1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (25) scan_step();
        rif.reg_we = 1'b1; rif.reg_addr = 4'd3; rif.reg_wdat = 16'd11; rif.reg_sel = 2'b11;
        m_hend_pend = 11;
        scan_step();
        rif.reg_we = 1'b0;
        #1;
        checks++;
        if (rif.reg_rdat !== 16'd11) begin errors++; $display("FAIL hend_readback: got %0d want 11", rif.reg_rdat); end
        repeat (130) scan_step();
    endtask

    task automatic test_line_irq();
        int n;
        configure(1'b0, 1'b0, 1'b1, 1'b1, 4);
        rif.reg_we = 1'b1; rif.reg_addr = 4'd14; rif.reg_wdat = 16'd2; rif.reg_sel = 2'b11;
        scan_step();
        rif.reg_addr = 4'd13; rif.reg_wdat = 16'd1;
        scan_step();
        rif.reg_we = 1'b0;
        n = 0;
        while (!(m_h == 1 && m_v == 4) && n < 100) begin scan_step(); n++; end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL line_irq_rise: got %b want 1", irq); end
        rif.reg_we = 1'b1; rif.reg_addr = 4'd13; rif.reg_wdat = 16'd2;
        scan_step();
        rif.reg_we = 1'b0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL line_irq_w1c: got %b want 0", irq); end
        n = 0;
        while (!(m_h == 0 && m_v == 4) && n < 100) begin scan_step(); n++; end
        rif.reg_we = 1'b1; rif.reg_addr = 4'd13; rif.reg_wdat = 16'd2;
        scan_step();
        rif.reg_we = 1'b0;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL line_irq_set_wins: got %b want 1", irq); end
        repeat (5) scan_step();
    endtask

    task automatic test_reset_mid();
        int n;
        configure(1'b0, 1'b0, 1'b0, 1'b0, 0);
        n = 0;
        while (!(m_h == 7 && m_v == 4) && n < 100) begin scan_step(); n++; end
        i_reset = 1'b1;
        @(negedge clk);
        checks++; if (hsync !== 1'b1)     begin errors++; $display("FAIL midrst_hsync: got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1)     begin errors++; $display("FAIL midrst_vsync: got %b want 1", vsync); end
        checks++; if ({blue, green, red} !== 8'h00) begin errors++; $display("FAIL midrst_colour: got %h want 00", {blue, green, red}); end
        checks++; if (pix_addr !== 24'h0) begin errors++; $display("FAIL midrst_pixaddr: got %h want 0", pix_addr); end
        checks++; if (irq !== 1'b0)       begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
        for (int i = 0; i < 16; i++) begin
            rif.reg_addr = 4'(i);
            #1;
            checks++;
            if (rif.reg_rdat !== 16'h0) begin errors++; $display("FAIL midrst_reg%0d: got %h want 0", i, rif.reg_rdat); end
        end
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        rif.reg_we = 1'b0; rif.reg_addr = 4'd0; rif.reg_wdat = 16'd0; rif.reg_sel = 2'b00;
        @(negedge clk);
        test_reset();
        test_scan();
        test_double();
        test_hend_change();
        test_line_irq();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
